exec_ctrl_resolve: RTL and testbench
====================================

Name: exec_ctrl_resolve

Overview:
- Parametrised control-resolution stage behind N control execution lanes. Generalises the single control-lane redirect path to NUM_LANES lanes.
- Registers per-lane branch results and selects the oldest mispredict by wrap-aware CTI age.
- Holds that redirect under a valid/ready handshake to the frontend.
- After acceptance, squashes younger wrong-path resolutions until the recovery flush arrives.

Parameters:
- NUM_LANES, 2, number of control execution lanes (1..4)
- PC_W, 32, program counter width
- CTI_LOG, 5, CTI ID width; IDs wrap modulo 2^CTI_LOG

Ports:
- clk  in  1  clock
- reset  in  1  reset
- flush_i  in  1  recoverFlag | exceptionFlag; clears all state next edge
- ctiHead_i  in  CTI_LOG  ID of oldest in-flight CTI (age reference)
- laneValid_i  in  NUM_LANES  lane k result valid this cycle
- laneMispred_i  in  NUM_LANES  lane k resolved target/direction differs from prediction
- laneDir_i  in  NUM_LANES  resolved direction
- laneNPC_i  in  NUM_LANES*PC_W  resolved next PC, lane k at bits [k*PC_W +: PC_W]
- laneCtiID_i  in  NUM_LANES*CTI_LOG  CTI ID per lane
- redirectValid_o  out  1  redirect pending
- redirectNPC_o  out  PC_W  redirect target
- redirectCtiID_o  out  CTI_LOG  CTI ID of redirecting branch
- redirectDir_o  out  1  resolved direction of redirecting branch
- redirectReady_i  in  1  frontend accepts redirect
- squash_o  out  1  high in WAIT_FLUSH state
- resolvedCnt_o  out  NUM_LANES+1  count of valid, non-squashed results registered last cycle

Behaviour:
- Reset: asynchronous, active-high. While asserted:
  - all outputs 0
  - stage-1 registers invalid
  - FSM in IDLE
- Stage 1: laneValid_i and payload are registered unconditionally each cycle. Fixed latency of 1 cycle before selection.
- Age: age_k = (ctiID_k - ctiHead_i) mod 2^CTI_LOG, unsigned CTI_LOG bits. ctiHead_i is sampled in the selection cycle, not in stage 1. Smaller age means older.
- Candidate: registered lane k with valid & mispred.
  - Oldest candidate wins.
  - On equal age, the lowest lane index wins.
- FSM states:
  - IDLE: a candidate exists -> load redirect register, go to PENDING.
  - PENDING: redirectValid_o=1.
    - If a new candidate is strictly older than the held redirect, replace it in the same cycle. The handshake then applies to the new value from the next cycle.
    - If redirectReady_i=1 and no replacement occurs, the redirect is accepted -> go to WAIT_FLUSH.
    - If a replacement and ready occur in the same cycle, the old value is accepted and the newer candidate is discarded.
  - WAIT_FLUSH: squash_o=1. All registered results are ignored and contribute 0 to resolvedCnt_o. Stay until flush_i.
- Output stability: redirect outputs hold constant in PENDING unless a replacement occurs.
- resolvedCnt_o: popcount of valid lanes, registered.
  - In PENDING, lanes strictly younger than the held redirect are excluded.
  - The redirecting branch itself is counted.
- flush_i, synchronous, highest priority:
  - next state IDLE
  - stage-1 valids cleared
  - redirectValid_o=0, squash_o=0
  - lane inputs presented in the flush cycle are dropped
- flush_i in PENDING with redirectReady_i=1: the flush wins and no acceptance occurs.
- Reset mid-operation: returns to the reset state immediately, regardless of FSM state.
- Wrap-around: ctiHead_i=30 with IDs 31 and 1 gives ages 1 and 3, so ID 31 is older.

Optional Feature:
- Macro: CTRL_RESOLVE_PERF_EN.
- When defined, adds outputs:
  - perfMispredCnt_o (32 bits): counts accepted redirects
  - perfSquashCnt_o (32 bits): counts valid results dropped in WAIT_FLUSH or excluded as younger in PENDING
- Both counters saturate at all-ones. Both reset to 0. Neither is cleared by flush_i.
- When undefined, the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Single redirect: NUM_LANES=2, ctiHead=0; lane1 valid+mispred, ID=3, NPC=0x1000.
  - Cycle+2: redirectValid_o=1, NPC=0x1000, ID=3.
  - With ready=1: WAIT_FLUSH, squash_o=1.
  - After flush_i: all outputs 0.
- Oldest select with wrap: ctiHead=30; lane0 ID=1 mispred, lane1 ID=31 mispred, same cycle -> redirectCtiID_o=31.
- Replacement while pending:
  - Pending on ID=5, ready=0; then lane0 ID=2 mispred -> next cycle redirectCtiID_o=2.
  - A later ID=7 mispred is not taken, and redirectCtiID_o stays 2.
- Squash counting: in WAIT_FLUSH both lanes valid for 3 cycles -> resolvedCnt_o=0. With PERF_EN, perfSquashCnt_o=6.
- Flush/ready collision: PENDING, redirectReady_i=1 and flush_i=1 same cycle -> next cycle IDLE, no acceptance. With PERF_EN, perfMispredCnt_o is unchanged.
- Async reset in PENDING: assert reset mid-cycle -> redirectValid_o drops before the next edge. A candidate presented after release is redirected normally.

Source files
------------

// File: rtl/exec_ctrl_resolve.sv
// Control-resolution stage: registers per-lane branch results, picks the oldest
// mispredict by wrap-aware CTI age, holds it for the frontend and squashes until flush.
// Optional perf counters are enabled with CTRL_RESOLVE_PERF_EN.

module exec_ctrl_resolve_lane #(
    parameter int PC_W    = 32,
    parameter int CTI_LOG = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               lane_valid,
    input  logic               lane_mispred,
    input  logic               lane_dir,
    input  logic [PC_W-1:0]    lane_npc,
    input  logic [CTI_LOG-1:0] lane_cti,
    input  logic [CTI_LOG-1:0] head,
    output logic               valid,
    output logic               mispred,
    output logic               dir,
    output logic [PC_W-1:0]    npc,
    output logic [CTI_LOG-1:0] cti,
    output logic [CTI_LOG-1:0] age
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            mispred <= 1'b0;
            dir     <= 1'b0;
            npc     <= '0;
            cti     <= '0;
        end else begin
            valid   <= lane_valid & ~flush;
            mispred <= lane_mispred;
            dir     <= lane_dir;
            npc     <= lane_npc;
            cti     <= lane_cti;
        end
    end

    // Age is taken against the head seen in the selection cycle.
    assign age = cti - head;
endmodule

module exec_ctrl_resolve #(
    parameter int NUM_LANES = 2,
    parameter int PC_W      = 32,
    parameter int CTI_LOG   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic [CTI_LOG-1:0]           ctiHead_i,
    input  logic [NUM_LANES-1:0]         laneValid_i,
    input  logic [NUM_LANES-1:0]         laneMispred_i,
    input  logic [NUM_LANES-1:0]         laneDir_i,
    input  logic [NUM_LANES*PC_W-1:0]    laneNPC_i,
    input  logic [NUM_LANES*CTI_LOG-1:0] laneCtiID_i,
    output logic                         redirectValid_o,
    output logic [PC_W-1:0]              redirectNPC_o,
    output logic [CTI_LOG-1:0]           redirectCtiID_o,
    output logic                         redirectDir_o,
    input  logic                         redirectReady_i,
    output logic                         squash_o,
    output logic [NUM_LANES:0]           resolvedCnt_o
`ifdef CTRL_RESOLVE_PERF_EN
    ,
    output logic [31:0]                  perfMispredCnt_o,
    output logic [31:0]                  perfSquashCnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, PENDING, WAIT_FLUSH} state_t;

    localparam logic [NUM_LANES:0] ONE = 1;

    state_t state, state_nxt;

    logic [NUM_LANES-1:0]              s1_valid, s1_mispred, s1_dir;
    logic [NUM_LANES-1:0][PC_W-1:0]    s1_npc;
    logic [NUM_LANES-1:0][CTI_LOG-1:0] s1_cti, s1_age;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        exec_ctrl_resolve_lane #(.PC_W(PC_W), .CTI_LOG(CTI_LOG)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .flush        (flush_i),
            .lane_valid   (laneValid_i[k]),
            .lane_mispred (laneMispred_i[k]),
            .lane_dir     (laneDir_i[k]),
            .lane_npc     (laneNPC_i[k*PC_W +: PC_W]),
            .lane_cti     (laneCtiID_i[k*CTI_LOG +: CTI_LOG]),
            .head         (ctiHead_i),
            .valid        (s1_valid[k]),
            .mispred      (s1_mispred[k]),
            .dir          (s1_dir[k]),
            .npc          (s1_npc[k]),
            .cti          (s1_cti[k]),
            .age          (s1_age[k])
        );
    end

    logic               cand_found, cand_dir;
    logic [PC_W-1:0]    cand_npc;
    logic [CTI_LOG-1:0] cand_cti, cand_age, held_age;

    // Strict compare keeps the lowest lane index on equal age.
    always_comb begin
        cand_found = 1'b0;
        cand_dir   = 1'b0;
        cand_npc   = '0;
        cand_cti   = '0;
        cand_age   = '1;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (s1_valid[k] && s1_mispred[k] && (!cand_found || s1_age[k] < cand_age)) begin
                cand_found = 1'b1;
                cand_dir   = s1_dir[k];
                cand_npc   = s1_npc[k];
                cand_cti   = s1_cti[k];
                cand_age   = s1_age[k];
            end
        end
    end

    assign held_age = redirectCtiID_o - ctiHead_i;

    logic load, accept;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cand_found) begin
                    load      = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                // Ready wins over a same-cycle replacement: the held value is taken.
                if (redirectReady_i) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_FLUSH;
                end else if (cand_found && cand_age < held_age) begin
                    load = 1'b1;
                end
            end
            WAIT_FLUSH: ;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            state_nxt = IDLE;
            load      = 1'b0;
            accept    = 1'b0;
        end
    end

    logic [NUM_LANES:0] cnt_nxt, drop_cnt;

    always_comb begin
        cnt_nxt  = '0;
        drop_cnt = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (s1_valid[k]) begin
                if (state == WAIT_FLUSH || (state == PENDING && s1_age[k] > held_age))
                    drop_cnt = drop_cnt + ONE;
                else
                    cnt_nxt = cnt_nxt + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            redirectNPC_o   <= '0;
            redirectCtiID_o <= '0;
            redirectDir_o   <= 1'b0;
            resolvedCnt_o   <= '0;
        end else begin
            state         <= state_nxt;
            resolvedCnt_o <= flush_i ? '0 : cnt_nxt;
            if (flush_i) begin
                redirectNPC_o   <= '0;
                redirectCtiID_o <= '0;
                redirectDir_o   <= 1'b0;
            end else if (load) begin
                redirectNPC_o   <= cand_npc;
                redirectCtiID_o <= cand_cti;
                redirectDir_o   <= cand_dir;
            end
        end
    end

    assign redirectValid_o = (state == PENDING);
    assign squash_o        = (state == WAIT_FLUSH);

`ifdef CTRL_RESOLVE_PERF_EN
    logic [32:0] squash_sum;
    assign squash_sum = {1'b0, perfSquashCnt_o} + 33'(drop_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perfMispredCnt_o <= '0;
            perfSquashCnt_o  <= '0;
        end else begin
            if (accept && perfMispredCnt_o != '1)
                perfMispredCnt_o <= perfMispredCnt_o + 32'd1;
            if (!flush_i)
                perfSquashCnt_o <= squash_sum[32] ? '1 : squash_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_exec_ctrl_resolve.sv
// Randomised scoreboard bench for exec_ctrl_resolve: a cycle-level reference model
// pushes expected outputs per edge, a monitor pops and compares after each edge.

module tb_exec_ctrl_resolve;
    localparam int NL = 2;
    localparam int PW = 32;
    localparam int CL = 5;

    logic clk = 1'b0;
    logic reset, flush, ready;
    logic [CL-1:0] head;
    logic [NL-1:0] lv, lm, ld;
    logic [NL*PW-1:0] lnpc;
    logic [NL*CL-1:0] lcti;
    logic r_valid, r_dir, squash;
    logic [PW-1:0] r_npc;
    logic [CL-1:0] r_cti;
    logic [NL:0] cnt;
`ifdef CTRL_RESOLVE_PERF_EN
    logic [31:0] perf_mis, perf_sq;
`endif

    always #5 clk = ~clk;

    exec_ctrl_resolve #(.NUM_LANES(NL), .PC_W(PW), .CTI_LOG(CL)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .ctiHead_i(head),
        .laneValid_i(lv), .laneMispred_i(lm), .laneDir_i(ld),
        .laneNPC_i(lnpc), .laneCtiID_i(lcti),
        .redirectValid_o(r_valid), .redirectNPC_o(r_npc), .redirectCtiID_o(r_cti),
        .redirectDir_o(r_dir), .redirectReady_i(ready), .squash_o(squash),
        .resolvedCnt_o(cnt)
`ifdef CTRL_RESOLVE_PERF_EN
        , .perfMispredCnt_o(perf_mis), .perfSquashCnt_o(perf_sq)
`endif
    );

    typedef struct packed {
        logic        v;
        logic [31:0] npc;
        logic [4:0]  id;
        logic        d;
        logic        sq;
        logic [2:0]  cnt;
    } exp_t;

    typedef struct {
        bit v, m, d;
        int unsigned npc, id;
    } res_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference state: last-registered results, held redirect and a phase number
    // (0 no redirect, 1 offering redirect, 2 waiting for flush).
    res_t s1[NL];
    int phase;
    int unsigned h_npc, h_id;
    bit h_dir;
    int unsigned m_cnt;

    function automatic int age(int unsigned id);
        return int'((id + 32 - int'(head)) % 32);
    endfunction

    task automatic model_reset();
        phase = 0; h_npc = 0; h_id = 0; h_dir = 0; m_cnt = 0;
        for (int k = 0; k < NL; k++) s1[k] = '{0, 0, 0, 0, 0};
    endtask

    task automatic set_lane(int k, bit v, bit m, bit d, int unsigned npc, int unsigned id);
        lv[k] = v; lm[k] = m; ld[k] = d;
        lnpc[k*PW +: PW] = npc;
        lcti[k*CL +: CL] = id[CL-1:0];
    endtask

    task automatic clear_lanes();
        lv = '0; lm = '0; ld = '0; lnpc = '0; lcti = '0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic step();
        exp_t e;
        int best, hage, c;
        if (flush) begin
            model_reset();
        end else begin
            best = -1;
            for (int k = 0; k < NL; k++)
                if (s1[k].v && s1[k].m && (best < 0 || age(s1[k].id) < age(s1[best].id)))
                    best = k;
            hage = age(h_id);
            c = 0;
            for (int k = 0; k < NL; k++)
                if (s1[k].v && !(phase == 2 || (phase == 1 && age(s1[k].id) > hage))) c++;
            m_cnt = c;
            if (phase == 0) begin
                if (best >= 0) begin
                    phase = 1; h_npc = s1[best].npc; h_id = s1[best].id; h_dir = s1[best].d;
                end
            end else if (phase == 1) begin
                if (ready) phase = 2;
                else if (best >= 0 && age(s1[best].id) < hage) begin
                    h_npc = s1[best].npc; h_id = s1[best].id; h_dir = s1[best].d;
                end
            end
            for (int k = 0; k < NL; k++)
                s1[k] = '{lv[k], lm[k], ld[k], lnpc[k*PW +: PW], int'(lcti[k*CL +: CL])};
        end
        e.v = (phase == 1); e.sq = (phase == 2);
        e.npc = h_npc; e.id = h_id[4:0]; e.d = h_dir; e.cnt = m_cnt[2:0];
        q.push_back(e);
    endtask

    task automatic tick();
        step();
        @(negedge clk);
        clear_lanes();
        flush = 1'b0;
    endtask

    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                a = '{r_valid, r_npc, r_cti, r_dir, squash, cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got v=%0b npc=%h id=%0d dir=%0b sq=%0b cnt=%0d, expected v=%0b npc=%h id=%0d dir=%0b sq=%0b cnt=%0d",
                             $time, a.v, a.npc, a.id, a.d, a.sq, a.cnt, e.v, e.npc, e.id, e.d, e.sq, e.cnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; ready = 1'b0; head = '0;
        clear_lanes();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({r_valid, r_npc, r_cti, r_dir, squash, cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b npc=%h id=%0d sq=%0b cnt=%0d, expected all 0",
                     r_valid, r_npc, r_cti, squash, cnt);
        end
        reset = 1'b0;

        // Single redirect, accept, flush
        head = 0;
        set_lane(1, 1, 1, 1, 32'h1000, 3); tick();
        tick(); tick();
        ready = 1; tick();
        ready = 0; tick();
        flush = 1; tick();
        tick();

        // Wrap-around oldest selection
        head = 30;
        set_lane(0, 1, 1, 0, 32'hA000, 1);
        set_lane(1, 1, 1, 1, 32'hB000, 31); tick();
        tick(); tick();
        flush = 1; tick();

        // Replacement while pending, younger one ignored
        head = 0;
        set_lane(0, 1, 1, 0, 32'h500, 5); tick();
        tick();
        set_lane(0, 1, 1, 1, 32'h200, 2); tick();
        tick();
        set_lane(1, 1, 1, 0, 32'h700, 7); tick();
        tick(); tick();
        // Squash counting in wait-flush
        ready = 1; tick();
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_lane(0, 1, 0, 0, 32'h10 + i, 8); set_lane(1, 1, 0, 0, 32'h20 + i, 9); tick();
        end
        tick();
        flush = 1; tick();

        // Flush and ready collide in pending
        set_lane(1, 1, 1, 0, 32'h4400, 4); tick();
        tick();
        ready = 1; flush = 1; tick();
        ready = 0; tick(); tick();

        // Asynchronous reset while pending
        set_lane(0, 1, 1, 0, 32'h6600, 6); tick();
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (r_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop: got redirectValid=%0b, expected 0", r_valid);
        end
        q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        set_lane(1, 1, 1, 0, 32'h7700, 12); tick();
        tick(); tick();
        ready = 1; tick();
        ready = 0; flush = 1; tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) head = CL'($urandom);
            for (int k = 0; k < NL; k++)
                set_lane(k, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                         1'($urandom), $urandom, $urandom_range(0, 31));
            ready = ($urandom_range(0, 2) == 0);
            flush = (phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
            tick();
        end
        ready = 0; flush = 1; tick();
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
